// File: rtl/serial_tx_buffer.sv
// Bus-attached serial transmitter: bytes written to DATA are queued in a FIFO and sent as 8N1 on tx.
// Optional sticky overflow flag in STATUS bit3 is built when SERIAL_TX_OVERFLOW_FLAG_EN is defined.
module serial_tx_buffer #(
    parameter int BASE         = 32,
    parameter int DEPTH_LOG2   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        tx,
    output logic        busy
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int CNT_W   = DEPTH_LOG2 + 1;
    localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
    localparam logic [31:0]       DATA_ADDR   = 32'(BASE);
    localparam logic [31:0]       STATUS_ADDR = 32'(BASE + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;

    state_t                state;
    state_t                state_next;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BAUD_W-1:0]     baud_next;
    logic [2:0]            bit_idx;
    logic [2:0]            bit_next;
    logic [7:0]            shift;
    logic [7:0]            shift_next;
    logic                  tx_next;

    logic                  full;
    logic                  empty;
    logic                  data_wr;
    logic                  rd_sel;
    logic                  push;
    logic                  pop;
    logic                  bit_end;
    logic                  overflow;
    logic [31:0]           status_word;
    logic                  unused_d_in;

    assign data_wr     = enable && rw && (addr == DATA_ADDR);
    assign rd_sel      = enable && !rw && ((addr == DATA_ADDR) || (addr == STATUS_ADDR));
    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign push        = data_wr && !full;
    assign bit_end     = (baud_cnt == BAUD_LAST);
    assign unused_d_in = ^d_in[31:8];

`ifdef SERIAL_TX_OVERFLOW_FLAG_EN
    logic status_wr;
    logic overflow_q;

    assign status_wr = enable && rw && (addr == STATUS_ADDR);
    assign overflow  = overflow_q;

    // Setting wins over clearing so an overflow in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (data_wr && full) begin
            overflow_q <= 1'b1;
        end else if (status_wr) begin
            overflow_q <= 1'b0;
        end
    end
`else
    assign overflow = 1'b0;
`endif

    always_comb begin
        status_word                  = '0;
        status_word[0]               = empty;
        status_word[1]               = full;
        status_word[2]               = (state != IDLE);
        status_word[3]               = overflow;
        status_word[8+DEPTH_LOG2:8]  = count;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= d_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // tx is registered from the current state, so the line lags the FSM by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            tx       <= tx_next;
            busy     <= !empty || (state != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = 1'b1;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out <= '0;
        end else if (rd_sel && (addr == STATUS_ADDR)) begin
            d_out <= status_word;
        end else begin
            d_out <= '0;
        end
    end

endmodule

// File: tb/tb_serial_tx_buffer.sv
// Self-checking bench for serial_tx_buffer: bytes are queued as expected results when written
// and popped when the serial line decoder recovers a frame.
module tb_serial_tx_buffer;

    localparam int BASE         = 32;
    localparam int DEPTH_LOG2   = 4;
    localparam int CLKS_PER_BIT = 16;
    localparam logic [31:0] DATA_A = 32'd32;
    localparam logic [31:0] STAT_A = 32'd33;
    localparam logic [31:0] FULL_STATUS = 32'h0000_1006;
`ifdef SERIAL_TX_OVERFLOW_FLAG_EN
    localparam logic [31:0] OVF_STATUS = 32'h0000_100E;
`else
    localparam logic [31:0] OVF_STATUS = 32'h0000_1006;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        tx;
    logic        busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [7:0] exp_q [$];

    serial_tx_buffer #(
        .BASE         (BASE),
        .DEPTH_LOG2   (DEPTH_LOG2),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .rw     (rw),
        .addr   (addr),
        .d_in   (d_in),
        .d_out  (d_out),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        enable = 1'b1;
        rw     = 1'b1;
        addr   = a;
        d_in   = d;
        @(negedge clk);
        enable = 1'b0;
        rw     = 1'b0;
        addr   = '0;
        d_in   = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        enable = 1'b1;
        rw     = 1'b0;
        addr   = a;
        @(negedge clk);
        d      = d_out;
        enable = 1'b0;
        addr   = '0;
    endtask

    // err: 0 = good frame, 1 = no start bit within budget, 2 = bad start/stop level
    task automatic receive_frame(input int budget, output logic [7:0] b,
                                 output int start_cyc, output int err);
        int waited;
        waited    = 0;
        b         = '0;
        start_cyc = 0;
        err       = 0;
        while (tx !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            err = 1;
            return;
        end
        start_cyc = cyc;
        repeat (CLKS_PER_BIT / 2) @(negedge clk);
        if (tx !== 1'b0) err = 2;
        for (int i = 0; i < 8; i++) begin
            repeat (CLKS_PER_BIT) @(negedge clk);
            b[i] = tx;
        end
        repeat (CLKS_PER_BIT) @(negedge clk);
        if (tx !== 1'b1) err = 2;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int errs;
        reset  = 1'b1;
        enable = 1'b0;
        rw     = 1'b0;
        addr   = '0;
        d_in   = '0;
        repeat (3) @(negedge clk);
        total++;
        if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b, expected 1", tx);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy);
        else passed++;
        total++;
        if (d_out !== 32'h0) $display("[TB] FAIL reset_dout: got %h, expected 00000000", d_out);
        else passed++;
        reset = 1'b0;
        errs  = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        total++;
        if (errs !== 0) $display("[TB] FAIL reset_idle: got %0d bad cycles, expected 0", errs);
        else passed++;
        bus_read(STAT_A, rd);
        total++;
        if (rd !== 32'h0000_0001) $display("[TB] FAIL reset_status: got %h, expected 00000001", rd);
        else passed++;
    endtask

    task automatic test_single_byte();
        logic [7:0] byte_val;
        logic [7:0] rx;
        logic [7:0] exp_b;
        logic       exp_tx;
        logic       exp_busy;
        int tx_errs;
        int busy_errs;
        int first_bad;
        byte_val  = 8'h41;
        rx        = '0;
        tx_errs   = 0;
        busy_errs = 0;
        first_bad = -1;
        exp_q.push_back(byte_val);
        bus_write(DATA_A, {24'h0, byte_val});
        for (int k = 0; k < 166; k++) begin
            if (k < 2)        exp_tx = 1'b1;
            else if (k < 18)  exp_tx = 1'b0;
            else if (k < 146) exp_tx = byte_val[(k - 18) / 16];
            else              exp_tx = 1'b1;
            exp_busy = (k >= 1 && k <= 161);
            if (tx !== exp_tx) begin
                tx_errs++;
                if (first_bad < 0) first_bad = k;
            end
            if (busy !== exp_busy) busy_errs++;
            if (k >= 26 && k < 154 && ((k - 26) % 16) == 0) rx[(k - 26) / 16] = tx;
            @(negedge clk);
        end
        total++;
        if (tx_errs !== 0)
            $display("[TB] FAIL single_tx_wave: got %0d bad cycles (first k=%0d), expected 0", tx_errs, first_bad);
        else passed++;
        total++;
        if (busy_errs !== 0) $display("[TB] FAIL single_busy_wave: got %0d bad cycles, expected 0", busy_errs);
        else passed++;
        exp_b = exp_q.pop_front();
        total++;
        if (rx !== exp_b) $display("[TB] FAIL single_byte: got %h, expected %h", rx, exp_b);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b1, b2, e1b, e2b;
        int s1, s2, err1, err2, w;
        exp_q.push_back(8'h55);
        bus_write(DATA_A, 32'h55);
        w = cyc;
        exp_q.push_back(8'hAA);
        bus_write(DATA_A, 32'hAA);
        receive_frame(400, b1, s1, err1);
        receive_frame(400, b2, s2, err2);
        e1b = exp_q.pop_front();
        e2b = exp_q.pop_front();
        total++;
        if (err1 !== 0 || b1 !== e1b)
            $display("[TB] FAIL b2b_frame1: got %h (err %0d), expected %h (err 0)", b1, err1, e1b);
        else passed++;
        total++;
        if (err2 !== 0 || b2 !== e2b)
            $display("[TB] FAIL b2b_frame2: got %h (err %0d), expected %h (err 0)", b2, err2, e2b);
        else passed++;
        total++;
        if (s1 - w !== 2) $display("[TB] FAIL b2b_latency: got %0d cycles, expected 2", s1 - w);
        else passed++;
        total++;
        if (s2 - s1 !== 161) $display("[TB] FAIL b2b_spacing: got %0d cycles, expected 161", s2 - s1);
        else passed++;
        repeat (20) @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("[TB] FAIL b2b_busy_idle: got %b, expected 0", busy);
        else passed++;
    endtask

    task automatic test_fill_overflow();
        logic [31:0] st;
        logic [7:0]  rb;
        logic [7:0]  eb;
        int rs, rerr;
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    exp_q.push_back(8'(i));
                    bus_write(DATA_A, 32'(i));
                end
                bus_read(STAT_A, st);
                total++;
                if (st !== FULL_STATUS) $display("[TB] FAIL fill_status: got %h, expected %h", st, FULL_STATUS);
                else passed++;
                bus_write(DATA_A, 32'h99);
                bus_read(STAT_A, st);
                total++;
                if (st !== OVF_STATUS) $display("[TB] FAIL overflow_status: got %h, expected %h", st, OVF_STATUS);
                else passed++;
                bus_write(STAT_A, 32'h0);
                bus_read(STAT_A, st);
                total++;
                if (st !== FULL_STATUS) $display("[TB] FAIL overflow_clear: got %h, expected %h", st, FULL_STATUS);
                else passed++;
            end
            begin
                for (int j = 0; j < 17; j++) begin
                    receive_frame(400, rb, rs, rerr);
                    eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    total++;
                    if (rerr !== 0 || rb !== eb)
                        $display("[TB] FAIL fill_frame%0d: got %h (err %0d), expected %h (err 0)", j, rb, rerr, eb);
                    else passed++;
                end
            end
        join
        total++;
        if (exp_q.size() !== 0) $display("[TB] FAIL fill_leftover: got %0d queued, expected 0", exp_q.size());
        else passed++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] st;
        logic [7:0]  rb;
        logic [7:0]  eb;
        int rs, rerr, w, errs;
        // the aborted 0xF0 frame never reaches the line, so it is not queued
        bus_write(DATA_A, 32'hF0);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (tx !== 1'b1) $display("[TB] FAIL midreset_tx: got %b, expected 1", tx);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b, expected 0", busy);
        else passed++;
        reset = 1'b0;
        bus_read(STAT_A, st);
        total++;
        if (st !== 32'h0000_0001) $display("[TB] FAIL midreset_status: got %h, expected 00000001", st);
        else passed++;
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) errs++;
        end
        total++;
        if (errs !== 0) $display("[TB] FAIL midreset_quiet: got %0d low cycles, expected 0", errs);
        else passed++;
        exp_q.push_back(8'h0F);
        bus_write(DATA_A, 32'h0F);
        w = cyc;
        receive_frame(400, rb, rs, rerr);
        eb = exp_q.pop_front();
        total++;
        if (rerr !== 0 || rb !== eb)
            $display("[TB] FAIL midreset_frame: got %h (err %0d), expected %h (err 0)", rb, rerr, eb);
        else passed++;
        total++;
        if (rs - w !== 2) $display("[TB] FAIL midreset_latency: got %0d cycles, expected 2", rs - w);
        else passed++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_address_decode();
        logic [31:0] st;
        int errs;
        bus_read(STAT_A, st);
        bus_write(32'(BASE + 2), 32'h77);
        total++;
        if (d_out !== 32'h0) $display("[TB] FAIL addr_dout_clear: got %h, expected 00000000", d_out);
        else passed++;
        bus_write(32'(BASE - 1), 32'h77);
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        total++;
        if (errs !== 0) $display("[TB] FAIL addr_no_frame: got %0d bad cycles, expected 0", errs);
        else passed++;
        bus_read(STAT_A, st);
        total++;
        if (st !== 32'h0000_0001) $display("[TB] FAIL addr_status: got %h, expected 00000001", st);
        else passed++;
        bus_read(32'(BASE + 2), st);
        total++;
        if (st !== 32'h0) $display("[TB] FAIL addr_read_plus2: got %h, expected 00000000", st);
        else passed++;
        bus_read(STAT_A, st);
        bus_read(32'(BASE - 1), st);
        total++;
        if (st !== 32'h0) $display("[TB] FAIL addr_read_minus1: got %h, expected 00000000", st);
        else passed++;
        bus_read(STAT_A, st);
        bus_read(DATA_A, st);
        total++;
        if (st !== 32'h0) $display("[TB] FAIL addr_read_data: got %h, expected 00000000", st);
        else passed++;
    endtask

    initial begin
        $display("[TB] serial_tx_buffer bench starting");
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fill_overflow();
        test_reset_mid_frame();
        test_address_decode();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
